// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// ALU opcodes, and the bit layout of the packed instruction word.
package alu_issue_ctrl_pkg;

  localparam int ALU_W    = 16;
  localparam int RF_DEPTH = 4;
  localparam int ADDR_W   = 2;
  localparam int INSTR_W  = 12;

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_e;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_NOTB = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_ADDC = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam int OP_LSB = 9;
  localparam int SH_LSB = 6;
  localparam int RD_LSB = 4;
  localparam int RA_LSB = 2;
  localparam int RB_LSB = 0;

  typedef struct packed {
    logic [2:0]        op;
    logic [2:0]        shift;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op    = raw[OP_LSB +: 3];
    d.shift = raw[SH_LSB +: 3];
    d.rd    = raw[RD_LSB +: ADDR_W];
    d.ra    = raw[RA_LSB +: ADDR_W];
    d.rb    = raw[RB_LSB +: ADDR_W];
    return d;
  endfunction

  // Only the adders produce a meaningful carry; logic ops report 0.
  function automatic logic carry_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADDC);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, load, ALU-side and status signals of alu_issue_ctrl.
// slave = controller side, master = instruction source / ALU / observer side.
interface alu_issue_ctrl_if #(parameter int DATA_W = 16);
  import alu_issue_ctrl_pkg::*;

  logic                instrValidIn;
  logic [INSTR_W-1:0]  instrIn;
  logic                instrReadyOut;
  logic                loadValidIn;
  logic [ADDR_W-1:0]   loadAddrIn;
  logic [DATA_W-1:0]   loadDataIn;
  logic [DATA_W-1:0]   aOut;
  logic [DATA_W-1:0]   bOut;
  logic [2:0]          shiftOut;
  logic [2:0]          opCodeOut;
  logic [DATA_W-1:0]   accIn;
  logic                crIn;
  logic                resultValidOut;
  logic [DATA_W-1:0]   resultOut;
  logic                zeroFlagOut;
  logic                carryFlagOut;

  modport slave (
    input  instrValidIn, instrIn, loadValidIn, loadAddrIn, loadDataIn, accIn, crIn,
    output instrReadyOut, aOut, bOut, shiftOut, opCodeOut,
           resultValidOut, resultOut, zeroFlagOut, carryFlagOut
  );

  modport master (
    output instrValidIn, instrIn, loadValidIn, loadAddrIn, loadDataIn, accIn, crIn,
    input  instrReadyOut, aOut, bOut, shiftOut, opCodeOut,
           resultValidOut, resultOut, zeroFlagOut, carryFlagOut
  );
endinterface

// File: rtl/alu_regfile.sv
// Operand register file: two async read ports, one write port shared by the
// ALU result and the load port (result wins on a same-address collision).
module alu_regfile #(
  parameter int DW = 16,
  parameter int RN = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  input  logic          res_we,
  input  logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [RN-1:0][DW-1:0] mem_q, mem_d;

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

  // Result applied last so it overrides a load to the same address.
  always_comb begin
    mem_d = mem_q;
    if (ld_we)  mem_d[ld_addr]  = ld_data;
    if (res_we) mem_d[res_addr] = res_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 16-bit ALU: IDLE -> ISSUE -> WRITE.
// Define ALU_ISSUE_PIPE_EN to accept in WRITE, with result forwarding.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_W,
  parameter int REG_N  = RF_DEPTH
) (
  input  logic             clockIn,
  input  logic             nResetIn,
  alu_issue_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d, shift_q, shift_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic                cr_q, cr_d, zero_q, zero_d, carry_q, carry_d;
  logic [DATA_W-1:0]   rf_a, rf_b;
  instr_t              ins;
  logic                rdy, accept;

  assign ins = decode(bus.instrIn);

`ifdef ALU_ISSUE_PIPE_EN
  assign rdy = (state_q == IDLE) || (state_q == WRITE);
`else
  assign rdy = (state_q == IDLE);
`endif
  assign accept = bus.instrValidIn && rdy;

  alu_regfile #(.DW(DATA_W), .RN(REG_N), .AW(ADDR_W)) u_rf (
    .clk       (clockIn),
    .rst_n     (nResetIn),
    .rd_addr_a (ins.ra),
    .rd_addr_b (ins.rb),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .res_we    (state_q == WRITE),
    .res_addr  (rd_q),
    .res_data  (acc_q),
    .ld_we     (bus.loadValidIn),
    .ld_addr   (bus.loadAddrIn),
    .ld_data   (bus.loadDataIn)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cr_d    = cr_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE:  ;
      ISSUE: begin
        acc_d   = bus.accIn;
        cr_d    = bus.crIn;
        state_d = WRITE;
      end
      WRITE: begin
        zero_d  = (acc_q == '0);
        carry_d = cr_q && carry_op(op_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accept overrides the WRITE->IDLE step when pipelining is enabled.
    if (accept) begin
      op_d    = ins.op;
      shift_d = ins.shift;
      rd_d    = ins.rd;
      a_d     = rf_a;
      b_d     = rf_b;
`ifdef ALU_ISSUE_PIPE_EN
      if (state_q == WRITE && ins.ra == rd_q) a_d = acc_q;
      if (state_q == WRITE && ins.rb == rd_q) b_d = acc_q;
`endif
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clockIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q <= IDLE;
      op_q    <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cr_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cr_q    <= cr_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.instrReadyOut  = rdy;
  assign bus.aOut           = a_q;
  assign bus.bOut           = b_q;
  assign bus.shiftOut       = shift_q;
  assign bus.opCodeOut      = op_q;
  assign bus.resultValidOut = (state_q == WRITE);
  assign bus.resultOut      = acc_q;
  assign bus.zeroFlagOut    = zero_q;
  assign bus.carryFlagOut   = carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; accept spacing follows ALU_ISSUE_PIPE_EN.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();
  alu_issue_ctrl dut (.clockIn(clk), .nResetIn(rst_n), .bus(bus));

`ifdef ALU_ISSUE_PIPE_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] sh,
                                     input logic [1:0] rd, input logic [1:0] ra,
                                     input logic [1:0] rb);
    return {op, sh, rd, ra, rb};
  endfunction

  // Accept one instruction from IDLE, feed the ALU result, drain to IDLE.
  task automatic do_instr(input logic [11:0] ins, input logic [15:0] acc, input logic cr,
                          output logic [15:0] a_obs, output logic [15:0] b_obs,
                          output logic [15:0] res_obs, output logic vld_obs);
    bus.instrValidIn = 1'b1;
    bus.instrIn      = ins;
    tick();
    bus.instrValidIn = 1'b0;
    bus.loadValidIn  = 1'b0;
    a_obs = bus.aOut;
    b_obs = bus.bOut;
    bus.accIn = acc;
    bus.crIn  = cr;
    tick();
    res_obs = bus.resultOut;
    vld_obs = bus.resultValidOut;
    tick();
  endtask

  initial begin
    logic [15:0] a, b, r;
    logic        v;
    logic [11:0] prog [3];
    logic [15:0] accs [3];
    logic [15:0] aseen [3];
    int          acc_cyc [3];
    int          n, cyc, vld_seen;
    logic        take;

    bus.instrValidIn = 1'b0;
    bus.instrIn      = '0;
    bus.loadValidIn  = 1'b0;
    bus.loadAddrIn   = '0;
    bus.loadDataIn   = '0;
    bus.accIn        = '0;
    bus.crIn         = 1'b0;

    tick(); tick();
    chk("rst_ready", bus.instrReadyOut, 1);
    chk("rst_rvalid", bus.resultValidOut, 0);
    chk("rst_a", bus.aOut, 0);
    chk("rst_b", bus.bOut, 0);
    chk("rst_res", bus.resultOut, 0);
    chk("rst_shift", bus.shiftOut, 0);
    chk("rst_op", bus.opCodeOut, 0);
    chk("rst_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 0);
    rst_n = 1'b1;
    tick();

    bus.loadValidIn = 1'b1; bus.loadAddrIn = 2'd0; bus.loadDataIn = 16'h0003;
    tick();
    bus.loadAddrIn = 2'd1; bus.loadDataIn = 16'h0005;
    tick();
    bus.loadValidIn = 1'b0;

    // ADD r2 = r0 + r1, checked phase by phase
    bus.instrValidIn = 1'b1;
    bus.instrIn = mk(OP_ADD, 3'd0, 2'd2, 2'd0, 2'd1);
    tick();
    bus.instrValidIn = 1'b0;
    chk("add_issue_op", bus.opCodeOut, OP_ADD);
    chk("add_issue_a", bus.aOut, 16'h0003);
    chk("add_issue_b", bus.bOut, 16'h0005);
    chk("add_issue_ready", bus.instrReadyOut, 0);
    chk("add_issue_rvalid", bus.resultValidOut, 0);
    bus.accIn = 16'h0008; bus.crIn = 1'b0;
    tick();
    chk("add_write_rvalid", bus.resultValidOut, 1);
    chk("add_write_res", bus.resultOut, 16'h0008);
    tick();
    chk("add_done_rvalid", bus.resultValidOut, 0);
    chk("add_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 2'b00);
    chk("add_ready", bus.instrReadyOut, 1);

    do_instr(mk(OP_XOR, 3'd0, 2'd0, 2'd0, 2'd0), 16'h0000, 1'b1, a, b, r, v);
    chk("xor_a", a, 16'h0003);
    chk("xor_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 2'b10);

    do_instr(mk(OP_ADD, 3'd0, 2'd3, 2'd0, 2'd2), 16'h0000, 1'b1, a, b, r, v);
    chk("add0_a_r0", a, 16'h0000);
    chk("add0_b_r2", b, 16'h0008);
    chk("add0_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 2'b11);

    do_instr(mk(OP_ADDC, 3'd5, 2'd3, 2'd0, 2'd0), 16'h0001, 1'b1, a, b, r, v);
    chk("addc_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 2'b01);
    chk("hold_shift", bus.shiftOut, 3'd5);
    chk("hold_op", bus.opCodeOut, OP_ADDC);

    do_instr(mk(OP_SUB, 3'd0, 2'd3, 2'd0, 2'd0), 16'h8000, 1'b1, a, b, r, v);
    chk("sub_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 2'b00);
    chk("sub_res", r, 16'h8000);

    // OR writing r2=0x1234 while a load of 0xBEEF hits r2 on the same edge
    bus.instrValidIn = 1'b1;
    bus.instrIn = mk(OP_OR, 3'd0, 2'd2, 2'd0, 2'd0);
    tick();
    bus.instrValidIn = 1'b0;
    bus.accIn = 16'h1234; bus.crIn = 1'b0;
    tick();
    chk("coll_rvalid", bus.resultValidOut, 1);
    bus.loadValidIn = 1'b1; bus.loadAddrIn = 2'd2; bus.loadDataIn = 16'hBEEF;
    tick();
    bus.loadValidIn = 1'b0;

    // Load r1 on the accept edge: operands must see the old value
    bus.loadValidIn = 1'b1; bus.loadAddrIn = 2'd1; bus.loadDataIn = 16'h7777;
    do_instr(mk(OP_AND, 3'd0, 2'd3, 2'd1, 2'd1), 16'h0001, 1'b0, a, b, r, v);
    chk("ld_same_accept_a", a, 16'h0005);
    chk("ld_same_accept_b", b, 16'h0005);

    do_instr(mk(OP_AND, 3'd0, 2'd3, 2'd2, 2'd1), 16'h0001, 1'b0, a, b, r, v);
    chk("coll_r2", a, 16'h1234);
    chk("ld_r1", b, 16'h7777);

    // Three back-to-back instructions with valid held high
    prog[0] = mk(OP_ADD, 3'd0, 2'd0, 2'd1, 2'd1); accs[0] = 16'h00AA;
    prog[1] = mk(OP_ADD, 3'd0, 2'd1, 2'd0, 2'd3); accs[1] = 16'h0055;
    prog[2] = mk(OP_AND, 3'd0, 2'd2, 2'd1, 2'd0); accs[2] = 16'h0000;
    n = 0; cyc = 0;
    bus.crIn = 1'b1;
    bus.instrValidIn = 1'b1;
    bus.instrIn = prog[0];
    while (n < 3 && cyc < 30) begin
      take = bus.instrReadyOut;
      tick();
      cyc++;
      if (take) begin
        acc_cyc[n] = cyc;
        aseen[n]   = bus.aOut;
        bus.accIn  = accs[n];
        n++;
        if (n < 3) bus.instrIn = prog[n];
        else       bus.instrValidIn = 1'b0;
      end
    end
    bus.instrValidIn = 1'b0;
    tick(); tick();
    chk("bb_accepted", n, 3);
    if (n == 3) begin
      chk("bb_spacing01", acc_cyc[1] - acc_cyc[0], SPACING);
      chk("bb_spacing12", acc_cyc[2] - acc_cyc[1], SPACING);
      chk("bb_dep_a1", aseen[1], 16'h00AA);
      chk("bb_dep_a2", aseen[2], 16'h0055);
    end
    chk("bb_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 2'b10);

    // Reset while in ISSUE discards the instruction
    bus.instrValidIn = 1'b1;
    bus.instrIn = mk(OP_ADD, 3'd3, 2'd3, 2'd0, 2'd1);
    tick();
    bus.instrValidIn = 1'b0;
    bus.accIn = 16'h4321; bus.crIn = 1'b1;
    chk("pre_rst_a", bus.aOut, 16'h00AA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", bus.aOut, 0);
    chk("mid_rst_b", bus.bOut, 0);
    chk("mid_rst_shift", bus.shiftOut, 0);
    chk("mid_rst_op", bus.opCodeOut, 0);
    chk("mid_rst_res", bus.resultOut, 0);
    chk("mid_rst_rvalid", bus.resultValidOut, 0);
    chk("mid_rst_flags", {bus.zeroFlagOut, bus.carryFlagOut}, 0);
    chk("mid_rst_ready", bus.instrReadyOut, 1);
    tick();
    rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.resultValidOut) vld_seen++;
    end
    chk("post_rst_no_rvalid", vld_seen, 0);
    chk("post_rst_ready", bus.instrReadyOut, 1);

    do_instr(mk(OP_AND, 3'd0, 2'd3, 2'd0, 2'd1), 16'h0001, 1'b0, a, b, r, v);
    chk("post_rst_r0", a, 16'h0000);
    chk("post_rst_r1", b, 16'h0000);
    chk("post_rst_instr_rvalid", v, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller sitting directly upstream of the 16-bit ALU. It holds a 4-entry × 16-bit operand register file and accepts packed instructions over a valid/ready handshake. For each instruction it drives operands, shift amount and opcode into the ALU, then captures the ALU result and carry back into the register file. It also maintains sticky-free zero and carry status flags for the last completed instruction.

## Interface
- `DATA_W`, 16: operand/result width (the ALU is fixed at 16)
- `REG_N`, 4: register file depth (address width `log2(REG_N)` = 2)
- `clockIn` in 1: single clock, rising edge
- `nResetIn` in 1: asynchronous, active-low reset
- `instrValidIn` in 1: instruction offered
- `instrIn` in 12: {op[11:9], shift[8:6], rd[5:4], ra[3:2], rb[1:0]}
- `instrReadyOut` out 1: controller can accept an instruction
- `loadValidIn` in 1: register-file write request (one cycle, no ready)
- `loadAddrIn` in 2: register to load
- `loadDataIn` in 16: load data
- `aOut`, `bOut` out 16: ALU operands (to ALU aIn/bIn)
- `shiftOut` out 3: ALU shift amount
- `opCodeOut` out 3: ALU opcode
- `accIn` in 16: ALU result (accOut)
- `crIn` in 1: ALU carry out
- `resultValidOut` out 1: one-cycle pulse, result written
- `resultOut` out 16: written result
- `zeroFlagOut`, `carryFlagOut` out 1: status of last completed instruction

## Operation
- FSM states: IDLE, ISSUE, WRITE. Reset → IDLE.
- IDLE: `instrReadyOut`=1. On valid&ready, latch op/shift/rd and read `reg[ra]`/`reg[rb]` into operand registers → ISSUE.
- ISSUE: `aOut`/`bOut`/`shiftOut`/`opCodeOut` are driven from the operand registers. At the closing edge, latch `accIn` and `crIn` → WRITE.
- WRITE: `resultValidOut`=1, `resultOut` = latched result. At the closing edge, write `reg[rd]` and update the flags → IDLE.
- `zeroFlagOut` = (result == 0).
- `carryFlagOut` = `crIn` for op 101 and 110. For all other ops it is 0.
- Outside ISSUE, `aOut`/`bOut`/`shiftOut`/`opCodeOut` hold their last values; they are not cleared.
- Load port works in any state.
  - Same-edge collision with a WRITE to the same address: the result write wins and the load is dropped.
  - Load to a different address proceeds normally.
- Operands are sampled at accept. A later load to `ra`/`rb` does not affect an in-flight instruction.
- Load in the same cycle as accept, to `ra` or `rb`: the old register value is read (no load forwarding).
- ra == rb == rd is legal.
- Reset mid-operation: the in-flight instruction is discarded with no register write and no `resultValidOut`.

## Timing
- Reset values:
  - `instrReadyOut`=1; `resultValidOut`=0.
  - `aOut`, `bOut`, `resultOut` = 0.
  - `shiftOut`, `opCodeOut` = 0.
  - Both flags = 0; all registers = 0.
- Latency: accept edge E0, ALU inputs valid E0→E1, result latched at E1, `resultValidOut` high E1→E2, register/flags updated at E2.
- Throughput: one instruction per 3 cycles (without `ALU_ISSUE_PIPE_EN`).
- `instrIn` is sampled only on valid&ready. The source holds `instrIn` stable while valid and not ready.

## Configuration
- `ALU_ISSUE_PIPE_EN` defined:
  - `instrReadyOut`=1 in WRITE as well as IDLE; accept in WRITE goes directly to ISSUE.
  - Throughput is one instruction per 2 cycles.
  - If the new instruction's `ra`/`rb` equals the completing `rd`, the completing result is forwarded into the operand register in place of the stale register value.
- `ALU_ISSUE_PIPE_EN` not defined: `instrReadyOut`=1 only in IDLE and there is no forwarding path.

## Structure
- Shared package holds:
  - state enum (IDLE/ISSUE/WRITE);
  - opcode constants (AND 000, OR 001, XOR 010, NOTA 011, NOTB 100, ADD 101, ADDC 110, SUB 111);
  - instruction field bit positions.
- One sub-module: `alu_regfile`, with 4×16 storage, two async read ports and one write port with priority arbitration between result write and load.

## Test plan
- Reset, then load r0=0x0003 and r1=0x0005; issue ADD (101), shift 0, rd=r2, ra=r0, rb=r1; return accIn=0x0008, crIn=0.
  - `opCodeOut`=101 and `aOut`=0x0003 in ISSUE.
  - `resultValidOut` pulses with 0x0008 two cycles after accept.
  - r2=0x0008, zero=0, carry=0.
- Issue XOR with ra=rb=rd=r0; return accIn=0x0000, crIn=1.
  - r0=0, zero=1, carry=0 (XOR ignores carry).
- Issue ADD with accIn=0x0000, crIn=1: zero=1, carry=1.
- Hold `instrValidIn` high continuously for three instructions:
  - accept spacing is 3 cycles without `ALU_ISSUE_PIPE_EN` and 2 cycles with it;
  - with the macro, a dependent `ra`=previous `rd` sees the forwarded result.
- Assert `loadValidIn` to r2 with 0xBEEF in the same cycle as the WRITE of rd=r2 with result 0x1234: r2=0x1234.
- Assert `nResetIn` low during ISSUE:
  - all outputs return to reset values;
  - no `resultValidOut`;
  - `instrReadyOut`=1 after release.
